// File: rtl/mode_register.sv
// mode_register: WIDTH-bit datapath register with load, inc/dec by STEP,
// serial shift, registered carry pulse and combinational zero flag.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset (out=RESET_VALUE, carry=0)
//   in         parallel load data
//   load       load in (highest priority)
//   inc, dec   add / subtract STEP; both together cancel (hold)
//   shift      shift one position (lowest active priority)
//   dir        0 = left toward MSB, 1 = right
//   serial_in  bit entering the vacated position
//   out        register contents
//   carry      one-cycle pulse: overflow, underflow or shifted-out bit
//   zero       1 when out == 0
module mode_register #(
    parameter int                WIDTH       = 16,
    parameter int unsigned       STEP        = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter bit                SATURATE    = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             shift,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             carry_q;
    logic             carry_d;

    // Arithmetic results are computed every cycle; the priority chain
    // below only picks which one (if any) is written back.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             underflow;

    always_comb begin
        sum       = {1'b0, out_q} + {1'b0, STEP_W};
        diff      = out_q - STEP_W;
        underflow = (out_q < STEP_W);
    end

    // Priority: load > inc/dec > shift > hold. The nested if chain makes
    // lower-priority controls irrelevant (including X) once a higher one
    // is active.
    always_comb begin
        out_d   = out_q;
        carry_d = 1'b0;
        if (load) begin
            out_d = in;
        end else if (inc || dec) begin
            if (inc && !dec) begin
                carry_d = sum[WIDTH];
                if (sum[WIDTH] && SATURATE) begin
                    out_d = '1;
                end else begin
                    out_d = sum[WIDTH-1:0];
                end
            end else if (dec && !inc) begin
                carry_d = underflow;
                if (underflow && SATURATE) begin
                    out_d = '0;
                end else begin
                    out_d = diff;
                end
            end
            // inc and dec together cancel: out holds, carry stays 0,
            // and a pending shift is deliberately suppressed.
        end else if (shift) begin
            if (dir) begin
                out_d   = {serial_in, out_q[WIDTH-1:1]};
                carry_d = out_q[0];
            end else begin
                out_d   = {out_q[WIDTH-2:0], serial_in};
                carry_d = out_q[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);

endmodule
